fetch_decode_unit: RTL and testbench
====================================

// Module: fetch_decode_unit
// PURPOSE
//  Front end of the core and the producer side of the instruction-queue interface.
//  Fetches RV32I words from instruction memory over a req/ready handshake and decodes them.
//  Presents each instruction as op/rs1/rs2/rd/imm/has_imm for exactly one clock edge, honouring iq_full.
//  Static not-taken: all control flow is resolved downstream and returned via jump_en/jump_addr.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC loaded on reset
// PORTS
//  clk        in   1   single clock, all state updates on posedge
//  rst        in   1   asynchronous, active-high reset
//  iq_full    in   1   queue cannot accept; no new op may be presented while high
//  jump_en    in   1   redirect/flush request from commit
//  jump_addr  in   32  redirect target (word aligned)
//  mem_req    out  1   fetch request, held until mem_ready
//  mem_addr   out  32  fetch address (= pc)
//  mem_ready  in   1   one-cycle pulse, mem_data valid
//  mem_data   in   32  fetched instruction word
//  op         out  5   decoded op; 5'b11111 = bubble/no instruction
//  rs1,rs2,rd out  5   register indices; 0 where field unused
//  imm        out  32  sign-extended immediate; 0 when has_imm=0
//  has_imm    out  1   1 for every op except register-register ALU
//  pc_out     out  32  address of the instruction presented on op
// BEHAVIOUR
//  Op encoding: LUI0 AUIPC1 JAL2 JALR3 BEQ4 BNE5 BLT6 BGE7 BLTU8 BGEU9 LB10 LH11 LW12
//   LBU13 LHU14 SB15 SH16 SW17 ADD18 SUB19 SLL20 SLT21 SLTU22 XOR23 SRL24 SRA25 OR26 AND27;
//   28-30 unused; 31 = NOP. OP-IMM reuses ALU codes with has_imm=1 (ADDI->18, SRAI->25).
//  Reset: op=5'h1F, rs*/rd/imm/has_imm/pc_out=0, mem_req=0, pc=RESET_PC, state=FETCH.
//  FSM: FETCH: drive mem_req=1, mem_addr=pc -> WAIT.
//       WAIT: hold req/addr; on mem_ready latch decoded fields, pc<=pc+4 -> EMIT.
//       EMIT: if !iq_full drive outputs for one cycle -> FETCH; else hold op=1F, stay.
//       DISCARD: wait for outstanding mem_ready, drop data -> FETCH.
//  Latency: mem_ready in cycle N -> op valid in cycle N+1 when iq_full=0.
//  op is non-1F for exactly one cycle per instruction; back-to-back gap >=2 cycles.
//  Immediates: I/S/B/U/J formats per RV32I, sign extended; U = {inst[31:12],12'b0};
//   shifts: imm = {27'b0, inst[24:20]}; SRLI/SRAI split by inst[30]; ADD/SUB by inst[30].
//  Illegal/unsupported word (incl. FENCE/SYSTEM): nothing emitted, pc still +4, -> FETCH.
//  jump_en (highest priority, any state): pc<=jump_addr; op forced 1F next cycle;
//   pending EMIT dropped; in WAIT without mem_ready -> DISCARD, else -> FETCH.
//   jump_en and mem_ready same cycle: data dropped, -> FETCH at jump_addr.
//  Async rst mid-transaction: immediate return to reset values; a later stray mem_ready is ignored in FETCH.
//  pc wraps modulo 2^32.
// STRUCTURE
//  Shared package: op enum (incl. OP_NOP=5'h1F), RV32I opcode/funct3 constants, FSM state typedef.
//  Sub-module: rv32i_decode (pure combinational word -> op/rs1/rs2/rd/imm/has_imm/illegal);
//  this block holds pc, FSM, output registers.
// TESTING
//  1 rst=1 -> op=1F, mem_req=0; release -> mem_req=1, mem_addr=0.
//  2 mem_data=32'h00500093 -> next cycle op=18 rd=1 rs1=0 imm=5 has_imm=1 pc_out=0; then mem_addr=4.
//  3 mem_data=32'hFE20AE23 -> op=17 rs1=1 rs2=2 rd=0 imm=32'hFFFFFFFC has_imm=1.
//  4 mem_data=32'h402081B3 with iq_full=1 for 3 cycles -> op=1F throughout, then op=19 rd=3 has_imm=0 for 1 cycle.
//  5 jump_en, jump_addr=32'h100 in WAIT; later mem_ready -> op stays 1F, next mem_addr=32'h100.
//  6 mem_data=32'hFFFFFFFF -> no op emitted, next mem_addr=pc+4.

Source files
------------

// File: rtl/fetch_decode_unit_pkg.sv
// Shared types for the fetch/decode front end: op codes, RV32I field constants,
// decoded-instruction record and fetch FSM states.
package fetch_decode_unit_pkg;

  typedef enum logic [4:0] {
    OP_LUI  = 5'd0,  OP_AUIPC = 5'd1,  OP_JAL  = 5'd2,  OP_JALR = 5'd3,
    OP_BEQ  = 5'd4,  OP_BNE   = 5'd5,  OP_BLT  = 5'd6,  OP_BGE  = 5'd7,
    OP_BLTU = 5'd8,  OP_BGEU  = 5'd9,  OP_LB   = 5'd10, OP_LH   = 5'd11,
    OP_LW   = 5'd12, OP_LBU   = 5'd13, OP_LHU  = 5'd14, OP_SB   = 5'd15,
    OP_SH   = 5'd16, OP_SW    = 5'd17, OP_ADD  = 5'd18, OP_SUB  = 5'd19,
    OP_SLL  = 5'd20, OP_SLT   = 5'd21, OP_SLTU = 5'd22, OP_XOR  = 5'd23,
    OP_SRL  = 5'd24, OP_SRA   = 5'd25, OP_OR   = 5'd26, OP_AND  = 5'd27,
    OP_NOP  = 5'h1F
  } op_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD = 3'b000, F3_SLL = 3'b001, F3_SLT = 3'b010, F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR = 3'b100, F3_SR  = 3'b101, F3_OR  = 3'b110, F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000, F3_BNE = 3'b001, F3_BLT = 3'b100, F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110, F3_BGEU = 3'b111;
  localparam logic [2:0] F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {ST_FETCH, ST_WAIT, ST_EMIT, ST_DISCARD} state_e;

  typedef struct packed {
    op_e         op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        has_imm;
  } dec_t;

  localparam dec_t DEC_NONE = '{OP_NOP, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0};

  // alt selects SUB/SRA; OP-IMM callers pass 0 for the add slot so ADDI never becomes SUB
  function automatic op_e alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  alu_op = alt ? OP_SUB : OP_ADD;
      F3_SLL:  alu_op = OP_SLL;
      F3_SLT:  alu_op = OP_SLT;
      F3_SLTU: alu_op = OP_SLTU;
      F3_XOR:  alu_op = OP_XOR;
      F3_SR:   alu_op = alt ? OP_SRA : OP_SRL;
      F3_OR:   alu_op = OP_OR;
      default: alu_op = OP_AND;
    endcase
  endfunction

endpackage

// File: rtl/fetch_decode_unit_rv32i_decode.sv
// Pure combinational RV32I word decoder; unsupported words flag illegal and decode as a bubble.
module rv32i_decode
  import fetch_decode_unit_pkg::*;
(
  input  logic [31:0] inst,
  output dec_t        dec,
  output logic        illegal
);

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_sh = {27'b0, inst[24:20]};

  always_comb begin
    dec     = DEC_NONE;
    illegal = 1'b0;
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC: begin
        dec.op      = (inst[5]) ? OP_LUI : OP_AUIPC;
        dec.rd      = inst[11:7];
        dec.imm     = imm_u;
        dec.has_imm = 1'b1;
      end
      OPC_JAL: begin
        dec.op      = OP_JAL;
        dec.rd      = inst[11:7];
        dec.imm     = imm_j;
        dec.has_imm = 1'b1;
      end
      OPC_JALR: begin
        dec.op      = OP_JALR;
        dec.rd      = inst[11:7];
        dec.rs1     = inst[19:15];
        dec.imm     = imm_i;
        dec.has_imm = 1'b1;
        illegal     = (f3 != F3_ADD);
      end
      OPC_BRANCH: begin
        dec.rs1     = inst[19:15];
        dec.rs2     = inst[24:20];
        dec.imm     = imm_b;
        dec.has_imm = 1'b1;
        case (f3)
          F3_BEQ:  dec.op = OP_BEQ;
          F3_BNE:  dec.op = OP_BNE;
          F3_BLT:  dec.op = OP_BLT;
          F3_BGE:  dec.op = OP_BGE;
          F3_BLTU: dec.op = OP_BLTU;
          F3_BGEU: dec.op = OP_BGEU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.rd      = inst[11:7];
        dec.rs1     = inst[19:15];
        dec.imm     = imm_i;
        dec.has_imm = 1'b1;
        case (f3)
          F3_B:    dec.op = OP_LB;
          F3_H:    dec.op = OP_LH;
          F3_W:    dec.op = OP_LW;
          F3_BU:   dec.op = OP_LBU;
          F3_HU:   dec.op = OP_LHU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec.rs1     = inst[19:15];
        dec.rs2     = inst[24:20];
        dec.imm     = imm_s;
        dec.has_imm = 1'b1;
        case (f3)
          F3_B:    dec.op = OP_SB;
          F3_H:    dec.op = OP_SH;
          F3_W:    dec.op = OP_SW;
          default: illegal = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        dec.rd      = inst[11:7];
        dec.rs1     = inst[19:15];
        dec.has_imm = 1'b1;
        if (f3 == F3_SLL || f3 == F3_SR) begin
          dec.op  = alu_op(f3, inst[30]);
          dec.imm = imm_sh;
          illegal = !(f7 == F7_BASE || (f7 == F7_ALT && f3 == F3_SR));
        end else begin
          dec.op  = alu_op(f3, 1'b0);
          dec.imm = imm_i;
        end
      end
      OPC_OP: begin
        dec.op  = alu_op(f3, inst[30]);
        dec.rd  = inst[11:7];
        dec.rs1 = inst[19:15];
        dec.rs2 = inst[24:20];
        illegal = !(f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)));
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) dec = DEC_NONE;
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// Instruction fetch FSM and decoded-instruction presentation towards the instruction queue.
module fetch_decode_unit
  import fetch_decode_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iq_full,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_data,
  output logic [4:0]  op,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic        has_imm,
  output logic [31:0] pc_out
);

  state_e      state;
  logic [31:0] pc;
  dec_t        dec_w;
  logic        illegal_w;
  dec_t        dec_p0;
  logic [31:0] pc_p0;

  rv32i_decode u_decode (
    .inst    (mem_data),
    .dec     (dec_w),
    .illegal (illegal_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_FETCH;
      pc       <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      {op, rs1, rs2, rd, imm, has_imm} <= DEC_NONE;
      pc_out   <= '0;
      dec_p0   <= DEC_NONE;
      pc_p0    <= '0;
    end else begin
      // outputs are a bubble unless an instruction is handed over this edge
      {op, rs1, rs2, rd, imm, has_imm} <= DEC_NONE;
      pc_out <= '0;
      if (jump_en) begin
        pc <= jump_addr;
        if ((state == ST_WAIT || state == ST_DISCARD) && !mem_ready) begin
          state <= ST_DISCARD;
        end else begin
          state   <= ST_FETCH;
          mem_req <= 1'b0;
        end
      end else begin
        case (state)
          ST_FETCH: begin
            mem_req  <= 1'b1;
            mem_addr <= pc;
            state    <= ST_WAIT;
          end
          ST_WAIT: begin
            if (mem_ready) begin
              mem_req <= 1'b0;
              pc      <= pc + 32'd4;
              if (illegal_w) begin
                state <= ST_FETCH;
              end else if (!iq_full) begin
                {op, rs1, rs2, rd, imm, has_imm} <= dec_w;
                pc_out <= mem_addr;
                state  <= ST_FETCH;
              end else begin
                dec_p0 <= dec_w;
                pc_p0  <= mem_addr;
                state  <= ST_EMIT;
              end
            end
          end
          ST_EMIT: begin
            if (!iq_full) begin
              {op, rs1, rs2, rd, imm, has_imm} <= dec_p0;
              pc_out <= pc_p0;
              state  <= ST_FETCH;
            end
          end
          ST_DISCARD: begin
            if (mem_ready) begin
              mem_req <= 1'b0;
              state   <= ST_FETCH;
            end
          end
          default: state <= ST_FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Scoreboard bench for fetch_decode_unit: a memory responder with a table-driven RV32I model
// queues expected instructions; a negedge monitor checks every presented op against the queue.
module tb_fetch_decode_unit;

  localparam int F_R = 0, F_I = 1, F_SH = 2, F_S = 3, F_B = 4, F_U = 5, F_J = 6;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    logic [4:0]  op;
    int          fmt;
  } pat_t;

  typedef struct {
    logic [4:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        has_imm;
    logic [31:0] pc;
    int          resp_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iq_full = 1'b0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_data = '0;
  logic [4:0]  op, rs1, rs2, rd;
  logic [31:0] imm;
  logic        has_imm;
  logic [31:0] pc_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit iqh [0:65535];

  pat_t        pats[$];
  exp_t        q[$];
  logic [31:0] prog_q[$];

  bit          outstanding = 0;
  bit          stale = 0;
  int          lat = 0;
  int          force_lat = -1;
  logic [31:0] req_addr = '0;
  logic [31:0] exp_pc = 32'h0;
  int          nreq = 0;

  fetch_decode_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .iq_full(iq_full), .jump_en(jump_en), .jump_addr(jump_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
    .op(op), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .has_imm(has_imm), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic add(input logic [31:0] m, input logic [31:0] mt, input logic [4:0] o, input int f);
    pat_t p;
    p.mask = m; p.match = mt; p.op = o; p.fmt = f;
    pats.push_back(p);
  endtask

  function automatic bit ref_decode(input logic [31:0] w, output exp_t e);
    e = '{default: 0};
    e.op = 5'h1F;
    foreach (pats[i]) begin
      if ((w & pats[i].mask) == pats[i].match) begin
        e.op = pats[i].op;
        e.has_imm = (pats[i].fmt != F_R);
        if (pats[i].fmt inside {F_R, F_I, F_SH, F_U, F_J}) e.rd = w[11:7];
        if (pats[i].fmt inside {F_R, F_I, F_SH, F_S, F_B}) e.rs1 = w[19:15];
        if (pats[i].fmt inside {F_R, F_S, F_B}) e.rs2 = w[24:20];
        case (pats[i].fmt)
          F_I:     e.imm = 32'($signed(w[31:20]));
          F_SH:    e.imm = 32'(w[24:20]);
          F_S:     e.imm = 32'($signed({w[31:25], w[11:7]}));
          F_B:     e.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
          F_U:     e.imm = {w[31:12], 12'h000};
          F_J:     e.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
          default: e.imm = 32'h0;
        endcase
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] rand_word();
    int k;
    if ($urandom_range(7, 0) == 0) return $urandom;
    k = $urandom_range(pats.size() - 1, 0);
    return ($urandom & ~pats[k].mask) | pats[k].match;
  endfunction

  // one clock of stimulus: drive inputs, play the memory, and queue what the DUT must present
  task automatic step(input bit j, input logic [31:0] ja, input bit full, input int maxlat);
    exp_t e;
    logic [31:0] w;
    @(posedge clk); #1;
    iq_full = full; jump_en = j; jump_addr = ja; mem_ready = 1'b0;
    if (mem_req && !outstanding) begin
      checks++; nreq++;
      if (mem_addr !== exp_pc) begin
        errors++;
        $display("FAIL fetch_addr: mem_addr=%h, required %h", mem_addr, exp_pc);
      end
      outstanding = 1; req_addr = mem_addr;
      lat = (force_lat >= 0) ? force_lat : $urandom_range(maxlat, 0);
    end
    if (outstanding) begin
      if (lat == 0) begin
        w = (prog_q.size() != 0) ? prog_q.pop_front() : rand_word();
        mem_ready = 1'b1; mem_data = w; outstanding = 0;
        if (j || stale) stale = 0;
        else begin
          if (ref_decode(w, e)) begin
            e.pc = req_addr; e.resp_cyc = cyc;
            q.push_back(e);
          end
          exp_pc = req_addr + 32'd4;
        end
      end else lat--;
    end
    if (j) begin
      if (outstanding) stale = 1;
      exp_pc = ja;
    end
  endtask

  task automatic run(input int n, input bit full, input int maxlat);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, full, maxlat);
  endtask

  // monitor: every non-bubble op must match the head of the queue and arrive on time
  initial forever begin
    exp_t e;
    int c;
    @(negedge clk);
    if (rst) q.delete();
    else begin
      iqh[cyc] = iq_full;
      if (op !== 5'h1F) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_op: op=%0d pc_out=%h, required bubble", op, pc_out);
        end else begin
          e = q.pop_front();
          if ({op, rs1, rs2, rd, imm, has_imm, pc_out} !== {e.op, e.rs1, e.rs2, e.rd, e.imm, e.has_imm, e.pc}) begin
            errors++;
            $display("FAIL decode: op=%0d rs1=%0d rs2=%0d rd=%0d imm=%h has_imm=%0b pc=%h, required op=%0d rs1=%0d rs2=%0d rd=%0d imm=%h has_imm=%0b pc=%h",
                     op, rs1, rs2, rd, imm, has_imm, pc_out, e.op, e.rs1, e.rs2, e.rd, e.imm, e.has_imm, e.pc);
          end
          c = e.resp_cyc;
          while (c < cyc && iqh[c]) c++;
          checks++;
          if (cyc != c + 1) begin
            errors++;
            $display("FAIL latency: op presented in cycle %0d, required cycle %0d", cyc, c + 1);
          end
        end
      end
      if (jump_en) q.delete();
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int n0;
    bit full_s;
    int k;
    add(32'h7F, 32'h37, 5'd0, F_U);        add(32'h7F, 32'h17, 5'd1, F_U);
    add(32'h7F, 32'h6F, 5'd2, F_J);        add(32'h707F, 32'h67, 5'd3, F_I);
    add(32'h707F, 32'h63, 5'd4, F_B);      add(32'h707F, 32'h1063, 5'd5, F_B);
    add(32'h707F, 32'h4063, 5'd6, F_B);    add(32'h707F, 32'h5063, 5'd7, F_B);
    add(32'h707F, 32'h6063, 5'd8, F_B);    add(32'h707F, 32'h7063, 5'd9, F_B);
    add(32'h707F, 32'h03, 5'd10, F_I);     add(32'h707F, 32'h1003, 5'd11, F_I);
    add(32'h707F, 32'h2003, 5'd12, F_I);   add(32'h707F, 32'h4003, 5'd13, F_I);
    add(32'h707F, 32'h5003, 5'd14, F_I);   add(32'h707F, 32'h23, 5'd15, F_S);
    add(32'h707F, 32'h1023, 5'd16, F_S);   add(32'h707F, 32'h2023, 5'd17, F_S);
    add(32'h707F, 32'h13, 5'd18, F_I);     add(32'h707F, 32'h2013, 5'd21, F_I);
    add(32'h707F, 32'h3013, 5'd22, F_I);   add(32'h707F, 32'h4013, 5'd23, F_I);
    add(32'h707F, 32'h6013, 5'd26, F_I);   add(32'h707F, 32'h7013, 5'd27, F_I);
    add(32'hFE00707F, 32'h1013, 5'd20, F_SH);      add(32'hFE00707F, 32'h5013, 5'd24, F_SH);
    add(32'hFE00707F, 32'h40005013, 5'd25, F_SH);  add(32'hFE00707F, 32'h33, 5'd18, F_R);
    add(32'hFE00707F, 32'h40000033, 5'd19, F_R);   add(32'hFE00707F, 32'h1033, 5'd20, F_R);
    add(32'hFE00707F, 32'h2033, 5'd21, F_R);       add(32'hFE00707F, 32'h3033, 5'd22, F_R);
    add(32'hFE00707F, 32'h4033, 5'd23, F_R);       add(32'hFE00707F, 32'h5033, 5'd24, F_R);
    add(32'hFE00707F, 32'h40005033, 5'd25, F_R);   add(32'hFE00707F, 32'h6033, 5'd26, F_R);
    add(32'hFE00707F, 32'h7033, 5'd27, F_R);

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (op !== 5'h1F || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: op=%0d mem_req=%0b, required op=31 mem_req=0", op, mem_req);
    end
    @(posedge clk); #1 rst = 1'b0;

    // ADDI x1,x0,5 answered immediately; the next request must be at 4
    prog_q.push_back(32'h00500093);
    force_lat = 0;
    step(1'b0, 32'h0, 1'b0, 0);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL req_after_reset: mem_req=%0b, required 1", mem_req);
    end
    run(3, 1'b0, 0);
    prog_q.push_back(32'hFE20AE23);
    run(4, 1'b0, 0);
    // SUB held back by a full queue
    prog_q.push_back(32'h402081B3);
    run(6, 1'b1, 0);
    run(4, 1'b0, 0);

    // redirect while a fetch is still outstanding
    force_lat = 4;
    k = 0;
    while (!outstanding && k < 10) begin step(1'b0, 32'h0, 1'b0, 0); k++; end
    checks++;
    if (!outstanding) begin
      errors++;
      $display("FAIL wait_state: no fetch request seen within 10 cycles, required one");
    end
    step(1'b1, 32'h100, 1'b0, 0);
    force_lat = 0;
    run(10, 1'b0, 0);

    prog_q.push_back(32'hFFFFFFFF);
    prog_q.push_back(32'h00000073);
    run(10, 1'b0, 0);

    // pc wrap past the top of memory
    step(1'b1, 32'hFFFFFFFC, 1'b0, 0);
    prog_q.push_back(32'h00100113);
    prog_q.push_back(32'h00208133);
    run(10, 1'b0, 0);

    // async reset in the middle of a fetch, then a stray mem_ready in FETCH
    force_lat = 3;
    k = 0;
    while (!outstanding && k < 10) begin step(1'b0, 32'h0, 1'b0, 0); k++; end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (op !== 5'h1F || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: op=%0d mem_req=%0b, required op=31 mem_req=0", op, mem_req);
    end
    outstanding = 0; stale = 0; exp_pc = 32'h0; force_lat = -1;
    iq_full = 1'b0; jump_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b1; mem_data = 32'h00500093;
    run(10, 1'b0, 2);

    n0 = nreq;
    full_s = 0;
    for (int i = 0; i < 2500; i++) begin
      bit j;
      logic [31:0] ja;
      if ($urandom_range(3, 0) == 0) full_s = !full_s;
      j = ($urandom_range(11, 0) == 0);
      ja = ($urandom_range(5, 0) == 0) ? 32'hFFFFFFF8 : ($urandom & 32'hFFFF_FFFC);
      step(j, ja, full_s, 3);
    end
    checks++;
    if (nreq - n0 < 100) begin
      errors++;
      $display("FAIL fetch_rate: %0d requests in random phase, required at least 100", nreq - n0);
    end

    k = 0;
    while (q.size() != 0 && k < 40) begin step(1'b0, 32'h0, 1'b0, 0); k++; end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d instructions never presented, required 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
